// File: rtl/wishbone_master_if.sv
// Request/response port and Wishbone classic bus of the single-transfer initiator.
// The master modport is the initiator side; the slave modport is its counterpart.
interface wishbone_master_if;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_we_i;
  logic [11:0] cmd_adr_i;
  logic [7:0]  cmd_dat_i;
  logic        rsp_valid_o;
  logic [7:0]  rsp_dat_o;
  logic [1:0]  rsp_status_o;
  logic [11:0] adr_o;
  logic        we_o;
  logic        stb_o;
  logic        cyc_o;
  logic [7:0]  dat_o;
  logic [7:0]  dat_i;
  logic        ack_i;
  logic        err_i;
  logic        rty_i;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, dat_i, ack_i, err_i, rty_i,
    output cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_status_o,
    output adr_o, we_o, stb_o, cyc_o, dat_o
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, dat_i, ack_i, err_i, rty_i,
    input  cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_status_o,
    input  adr_o, we_o, stb_o, cyc_o, dat_o
  );
endinterface

// File: rtl/wishbone_master.sv
// Wishbone classic single-transfer initiator with bounded retry on rty.
// Define WB_MASTER_TIMEOUT_EN to build the watchdog that aborts a silent cycle.
module wishbone_master #(
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 15
) (
  input logic                clk_i,
  input logic                rst_i,
  wishbone_master_if.master  bus
);

  typedef enum logic [1:0] {IDLE, BUS, BACKOFF, DONE} state_t;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_ERR     = 2'b01;
  localparam logic [1:0] ST_RETRY   = 2'b10;
  localparam logic [1:0] ST_TIMEOUT = 2'b11;

  if (MAX_RETRY < 0 || MAX_RETRY > 15) begin : g_bad_max_retry
    $error("wishbone_master: MAX_RETRY must be 0..15");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("wishbone_master: TIMEOUT must be 1..255");
  end

  state_t     state;
  logic [3:0] retry_cnt;
`ifdef WB_MASTER_TIMEOUT_EN
  logic [7:0] tmo_cnt;
`endif

  logic       bus_done;
  logic       bus_retry;
  logic [1:0] bus_status;
  logic [7:0] bus_rdata;

  assign bus.cmd_ready_o = (state == IDLE) && !rst_i;

  // Termination decode while in BUS; err beats ack beats rty beats the watchdog.
  // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    bus_done   = 1'b0;
    bus_retry  = 1'b0;
    bus_status = ST_OK;
    bus_rdata  = '0;
    if (bus.err_i) begin
      bus_done   = 1'b1;
      bus_status = ST_ERR;
    end else if (bus.ack_i) begin
      bus_done  = 1'b1;
      bus_rdata = bus.we_o ? 8'h00 : bus.dat_i;
    end else if (bus.rty_i) begin
      if (retry_cnt < 4'(MAX_RETRY)) begin
        bus_retry = 1'b1;
      end else begin
        bus_done   = 1'b1;
        bus_status = ST_RETRY;
      end
    end
`ifdef WB_MASTER_TIMEOUT_EN
    else if (tmo_cnt == 8'(TIMEOUT - 1)) begin
      bus_done   = 1'b1;
      bus_status = ST_TIMEOUT;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state            <= IDLE;
      retry_cnt        <= '0;
`ifdef WB_MASTER_TIMEOUT_EN
      tmo_cnt          <= '0;
`endif
      bus.cyc_o        <= 1'b0;
      bus.stb_o        <= 1'b0;
      bus.we_o         <= 1'b0;
      bus.adr_o        <= '0;
      bus.dat_o        <= '0;
      bus.rsp_valid_o  <= 1'b0;
      bus.rsp_dat_o    <= '0;
      bus.rsp_status_o <= ST_OK;
    end else begin
      bus.rsp_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cmd_valid_i) begin
            // adr_o/we_o/dat_o double as the command latch for the whole transfer
            bus.adr_o <= bus.cmd_adr_i;
            bus.we_o  <= bus.cmd_we_i;
            bus.dat_o <= bus.cmd_we_i ? bus.cmd_dat_i : 8'h00;
            retry_cnt <= '0;
`ifdef WB_MASTER_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
            bus.cyc_o <= 1'b1;
            bus.stb_o <= 1'b1;
            state     <= BUS;
          end
        end
        BUS: begin
          if (bus_done) begin
            bus.cyc_o        <= 1'b0;
            bus.stb_o        <= 1'b0;
            bus.rsp_valid_o  <= 1'b1;
            bus.rsp_status_o <= bus_status;
            bus.rsp_dat_o    <= bus_rdata;
            state            <= DONE;
          end else if (bus_retry) begin
            retry_cnt <= retry_cnt + 4'd1;
            bus.cyc_o <= 1'b0;
            bus.stb_o <= 1'b0;
            state     <= BACKOFF;
          end else begin
`ifdef WB_MASTER_TIMEOUT_EN
            tmo_cnt <= tmo_cnt + 8'd1;
`endif
          end
        end
        BACKOFF: begin
`ifdef WB_MASTER_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
          bus.cyc_o <= 1'b1;
          bus.stb_o <= 1'b1;
          state     <= BUS;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wishbone_master.sv
// Self-checking bench for wishbone_master: scripted slave model plus a response scoreboard.
// Honours WB_MASTER_TIMEOUT_EN the same way as the design.
module tb_wishbone_master;

  typedef struct packed {
    logic [1:0] status;
    logic [7:0] dat;
  } rsp_t;

  logic clk;
  logic rst;
  wishbone_master_if bus();

  wishbone_master #(.MAX_RETRY(3), .TIMEOUT(15)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int   n_cmp = 0;
  int   n_err = 0;
  rsp_t exp_q[$];

  // slave script
  int         slv_wait    = 0;
  int         slv_rty_n   = 0;
  bit         slv_err     = 0;
  bit         slv_both    = 0;
  bit         slv_silent  = 0;
  logic [7:0] slv_rdata   = 8'h00;
  int         slv_wcnt    = 0;
  int         slv_attempt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Slave: after slv_wait wait cycles per attempt, answers rty for the first slv_rty_n attempts.
  initial begin
    bus.ack_i = 1'b0;
    bus.err_i = 1'b0;
    bus.rty_i = 1'b0;
    bus.dat_i = 8'h00;
    forever begin
      @(negedge clk);
      bus.ack_i = 1'b0;
      bus.err_i = 1'b0;
      bus.rty_i = 1'b0;
      bus.dat_i = slv_rdata;
      if (bus.stb_o && !slv_silent) begin
        if (slv_wcnt == slv_wait) begin
          slv_wcnt = 0;
          if (slv_attempt < slv_rty_n) bus.rty_i = 1'b1;
          else if (slv_both) begin
            bus.ack_i = 1'b1;
            bus.err_i = 1'b1;
          end else if (slv_err) bus.err_i = 1'b1;
          else bus.ack_i = 1'b1;
          slv_attempt++;
        end else begin
          slv_wcnt++;
        end
      end else if (!bus.stb_o) begin
        slv_wcnt = 0;
      end
    end
  end

  task automatic set_slave(input int w, input int r, input bit e, input bit b, input bit s,
                           input logic [7:0] rd);
    slv_wait   = w;
    slv_rty_n  = r;
    slv_err    = e;
    slv_both   = b;
    slv_silent = s;
    slv_rdata  = rd;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ctrl", {bus.cyc_o, bus.stb_o, bus.we_o, bus.rsp_valid_o, bus.cmd_ready_o}, 0);
    check("rst_data", {bus.adr_o, bus.dat_o, bus.rsp_dat_o, bus.rsp_status_o}, 0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", bus.cmd_ready_o, 1);
  endtask

  task automatic run_cmd(input logic we, input logic [11:0] adr, input logic [7:0] dat,
                         input bit exp_rsp, input logic [1:0] exp_st, input int exp_lat,
                         input int exp_stb, input int exp_gaps, input int budget);
    rsp_t e;
    rsp_t g;
    int   stb_cnt = 0;
    int   gaps = 0;
    int   lat = 0;
    int   adr_bad = 0;
    bit   got = 0;
    e.status = exp_st;
    e.dat    = (exp_st == 2'b00 && !we) ? slv_rdata : 8'h00;
    if (exp_rsp) exp_q.push_back(e);

    @(negedge clk);
    slv_attempt     = 0;
    slv_wcnt        = 0;
    bus.cmd_valid_i = 1'b1;
    bus.cmd_we_i    = we;
    bus.cmd_adr_i   = adr;
    bus.cmd_dat_i   = dat;
    for (int i = 0; i < 20 && !bus.cmd_ready_o; i++) @(negedge clk);
    check("cmd_ready", bus.cmd_ready_o, 1);
    @(posedge clk);

    for (int c = 1; c <= budget && !got; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.cmd_valid_i = 1'b0;
        check("issue", {bus.cyc_o, bus.stb_o, bus.we_o, bus.adr_o, bus.dat_o},
              {1'b1, 1'b1, we, adr, (we ? dat : 8'h00)});
      end
      if (bus.stb_o) begin
        stb_cnt++;
        if (bus.adr_o !== adr || bus.we_o !== we) adr_bad++;
      end
      if (!bus.cyc_o && !bus.rsp_valid_o) gaps++;
      if (bus.rsp_valid_o) begin
        got = 1;
        lat = c;
        check("sb_size", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
          g = exp_q.pop_front();
          check("rsp_status", bus.rsp_status_o, g.status);
          check("rsp_dat", bus.rsp_dat_o, g.dat);
        end
      end
    end

    check("adr_stable", adr_bad, 0);
    check("stb_cycles", stb_cnt, exp_stb);
    check("cyc_gaps", gaps, exp_gaps);
    if (exp_rsp) begin
      check("got_rsp", got, 1);
      check("latency", lat, exp_lat);
      @(negedge clk);
      check("idle_after", {bus.rsp_valid_o, bus.cyc_o, bus.cmd_ready_o}, 3'b001);
      check("rsp_hold", {bus.rsp_status_o, bus.rsp_dat_o}, {e.status, e.dat});
    end else begin
      check("no_rsp", got, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic       rwe;
    logic [11:0] radr;
    logic [7:0]  rdat;
    int          rw;
    int          quiet;

    rst             = 1'b1;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_we_i    = 1'b0;
    bus.cmd_adr_i   = '0;
    bus.cmd_dat_i   = '0;
    #2;
    check("ready_in_rst", bus.cmd_ready_o, 0);
    apply_reset();

    // zero-wait write; slave drives junk read data that must not leak into rsp_dat_o
    set_slave(0, 0, 0, 0, 0, 8'hFF);
    run_cmd(1'b1, 12'h3A5, 8'h5C, 1, 2'b00, 2, 1, 0, 50);
    // read, three wait states
    set_slave(3, 0, 0, 0, 0, 8'hA7);
    run_cmd(1'b0, 12'h1B2, 8'h00, 1, 2'b00, 5, 4, 0, 50);
    // two rty then ack
    set_slave(0, 2, 0, 0, 0, 8'h3C);
    run_cmd(1'b0, 12'h0F0, 8'h00, 1, 2'b00, 6, 3, 2, 50);
    // permanent rty: four attempts then retries exhausted
    set_slave(0, 1000, 0, 0, 0, 8'h77);
    run_cmd(1'b1, 12'h800, 8'h11, 1, 2'b10, 8, 4, 3, 50);
    // err and ack together: err wins
    set_slave(0, 0, 0, 1, 0, 8'h99);
    run_cmd(1'b0, 12'h456, 8'h00, 1, 2'b01, 2, 1, 0, 50);
    // err after one wait state
    set_slave(1, 0, 1, 0, 0, 8'h00);
    run_cmd(1'b1, 12'h001, 8'hC3, 1, 2'b01, 3, 2, 0, 50);
    // address/data extremes
    set_slave(0, 0, 0, 0, 0, 8'h5A);
    run_cmd(1'b1, 12'hFFF, 8'hFF, 1, 2'b00, 2, 1, 0, 50);
    run_cmd(1'b0, 12'h000, 8'h00, 1, 2'b00, 2, 1, 0, 50);
    // mixed random traffic
    for (int i = 0; i < 4; i++) begin
      rwe  = 1'($urandom_range(0, 1));
      radr = 12'($urandom);
      rdat = 8'($urandom);
      rw   = int'($urandom_range(0, 2));
      set_slave(rw, 0, 0, 0, 0, 8'($urandom));
      run_cmd(rwe, radr, rdat, 1, 2'b00, rw + 2, rw + 1, 0, 50);
    end

    // silent slave
    set_slave(0, 0, 0, 0, 1, 8'h00);
`ifdef WB_MASTER_TIMEOUT_EN
    run_cmd(1'b0, 12'h2C4, 8'h00, 1, 2'b11, 16, 15, 0, 50);
`else
    run_cmd(1'b0, 12'h2C4, 8'h00, 0, 2'b00, 0, 110, 0, 110);
    apply_reset();
`endif

    // reset asserted during a wait state
    set_slave(20, 0, 0, 0, 0, 8'h42);
    @(negedge clk);
    slv_attempt     = 0;
    slv_wcnt        = 0;
    bus.cmd_valid_i = 1'b1;
    bus.cmd_we_i    = 1'b0;
    bus.cmd_adr_i   = 12'h123;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    check("stb_before_rst", bus.stb_o, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_async", {bus.cyc_o, bus.stb_o, bus.rsp_valid_o, bus.cmd_ready_o}, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_release", {bus.cmd_ready_o, bus.cyc_o}, 2'b10);
    quiet = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.rsp_valid_o || bus.cyc_o) quiet++;
    end
    check("quiet_after_rst", quiet, 0);

    // recovery
    set_slave(0, 0, 0, 0, 0, 8'hE1);
    run_cmd(1'b0, 12'h321, 8'h00, 1, 2'b00, 2, 1, 0, 50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
